// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling from an internal bit-period counter.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int CLKS_PER_BIT = 651,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_s_q;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;
    logic            par_q, par_d;
    logic            perr_q, perr_d;
    logic            bit_tick;

    assign bit_tick = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        par_d     = par_q;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                // A start bit that is high again at its midpoint was only a glitch.
                if (clk_cnt_q == CW'(HALF_BIT - 1)) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    par_d     = rx_s_q;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid stop bit so a start edge right after it is not missed.
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    data_d    = shift_q;
                    if (!rx_s_q) begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end else begin
                        if (par_q != ^shift_q) perr_d = 1'b1;
                        else                   valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                clk_cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifndef UART_RX_PARITY_EN
        par_d  = ^shift_d;
        perr_d = 1'b0;
`endif
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            par_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            par_q     <= par_d;
            busy_q    <= busy_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_q;
`endif
endmodule
